// File: rtl/data_mem_responder_pkg.sv
// Shared types and defaults for the MEM-stage data memory responder.
// Sized by DMEM_DEPTH words, with a fixed access latency of DMEM_WAIT cycles.
package data_mem_responder_pkg;

  typedef enum logic [1:0] {
    MEM_IDLE = 2'd0,
    MEM_BUSY = 2'd1,
    MEM_RESP = 2'd2
  } mem_state_t;

  localparam int DMEM_DEPTH = 64;
  localparam int DMEM_WAIT  = 3;

endpackage

// File: rtl/data_mem_responder_ram.sv
// Single-port synchronous data RAM: write on the clock edge when we=1, registered read.
// The contents are not reset.
module data_ram #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 64,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rdata_q;
  logic [DATA_W-1:0] rdata_d;

  always_comb begin
    rdata_d = mem[addr];
  end

  // Read returns the old word on a same-edge write; accesses are serialized, so this is never observed.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/data_mem_responder.sv
// MEM-stage responder: accepts one LD/ST at a time, holds the pipeline with freeze for
// WAIT_CYCLES+1 cycles, then pulses ready for one cycle with load data in mem_rdata.
//
// Handshake: a request is the level of exactly one of MEM_R_EN/MEM_W_EN in IDLE with an
// in-range address. It is accepted in that cycle, when freeze rises combinationally.
// Request inputs are ignored until the cycle after the ready strobe.
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int DEPTH       = DMEM_DEPTH,
  parameter int WAIT_CYCLES = DMEM_WAIT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              MEM_R_EN,
  input  logic              MEM_W_EN,
  input  logic [ADDR_W-1:0] ALU_result,
  input  logic [DATA_W-1:0] ST_value,
  output logic              freeze,
  output logic              ready,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              addr_err,
  output mem_state_t        dbg_state
);

  localparam int IDX_W = $clog2(DEPTH);

  mem_state_t        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]  addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              is_wr_q, is_wr_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;

  logic [ADDR_W-3:0] word_idx;
  logic              in_range;
  logic              one_req;
  logic              any_req;
  logic              ram_we;
  logic [IDX_W-1:0]  ram_addr;
  logic [DATA_W-1:0] ram_rdata;

  assign word_idx = ALU_result[ADDR_W-1:2];
  assign in_range = word_idx < (ADDR_W-2)'(DEPTH);
  assign one_req  = MEM_R_EN ^ MEM_W_EN;
  assign any_req  = MEM_R_EN | MEM_W_EN;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    is_wr_d = is_wr_q;
    rdata_d = rdata_q;
    err_d   = 1'b0;
    freeze  = 1'b0;
    ram_we  = 1'b0;
    case (state_q)
      MEM_IDLE: begin
        if (one_req && in_range) begin
          state_d = MEM_BUSY;
          cnt_d   = 4'(WAIT_CYCLES - 1);
          addr_d  = word_idx[IDX_W-1:0];
          wdata_d = ST_value;
          is_wr_d = MEM_W_EN;
          freeze  = 1'b1;
        end else if (any_req) begin
          err_d = 1'b1;
          if (MEM_R_EN && !MEM_W_EN) begin
            rdata_d = '0;
          end
        end
      end
      MEM_BUSY: begin
        freeze = 1'b1;
        if (cnt_q == 4'd0) begin
          state_d = MEM_RESP;
          if (is_wr_q) begin
            ram_we = !rst;
          end else begin
            rdata_d = ram_rdata;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      MEM_RESP: begin
        state_d = MEM_IDLE;
      end
      default: begin
        state_d = MEM_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= MEM_IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= '0;
      wdata_q <= '0;
      is_wr_q <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      is_wr_q <= is_wr_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // In IDLE the RAM is addressed by the incoming request, so read data is ready after one BUSY cycle.
  assign ram_addr = (state_q == MEM_IDLE) ? word_idx[IDX_W-1:0] : addr_q;

  data_ram #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we),
    .addr (ram_addr),
    .wdata(wdata_q),
    .rdata(ram_rdata)
  );

  assign ready     = (state_q == MEM_RESP);
  assign mem_rdata = rdata_q;
  assign addr_err  = err_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder: reset, a directed vector table, a reset-mid-store
// sequence, and random traffic checked against a word-array reference model.
module tb_data_mem_responder;
  import data_mem_responder_pkg::*;

  localparam int WAIT = 3;
  localparam int DEPTH = 64;

  logic        clk;
  logic        rst;
  logic        MEM_R_EN;
  logic        MEM_W_EN;
  logic [31:0] ALU_result;
  logic [31:0] ST_value;
  logic        freeze;
  logic        ready;
  logic [31:0] mem_rdata;
  logic        addr_err;
  mem_state_t  dbg_state;

  int checks;
  int errors;

  logic [31:0] model_mem [DEPTH];
  logic [31:0] model_rdata;

  typedef struct {
    logic        r;
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
    logic        e;
    logic [31:0] er;
  } vec_t;

  vec_t tbl [12];

  data_mem_responder #(
    .DATA_W(32),
    .ADDR_W(32),
    .DEPTH(DEPTH),
    .WAIT_CYCLES(WAIT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .MEM_R_EN(MEM_R_EN),
    .MEM_W_EN(MEM_W_EN),
    .ALU_result(ALU_result),
    .ST_value(ST_value),
    .freeze(freeze),
    .ready(ready),
    .mem_rdata(mem_rdata),
    .addr_err(addr_err),
    .dbg_state(dbg_state)
  );

  // Clock and watchdog.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  // Drive one instruction from the current cycle start and check it cycle by cycle.
  task automatic run_op(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic e, input logic [31:0] er, input string nm);
    MEM_R_EN = r;
    MEM_W_EN = w;
    ALU_result = a;
    ST_value = d;
    if (!e) begin
      for (int k = 0; k <= WAIT; k++) begin
        @(negedge clk);
        check({nm, " freeze"}, 32'(freeze), 32'd1);
        check({nm, " ready_low"}, 32'(ready), 32'd0);
        if (k == 0) check({nm, " err_low"}, 32'(addr_err), 32'd0);
        @(posedge clk); #1;
      end
      @(negedge clk);
      check({nm, " ready"}, 32'(ready), 32'd1);
      check({nm, " freeze_low"}, 32'(freeze), 32'd0);
      check({nm, " rdata"}, mem_rdata, er);
      check({nm, " err_resp"}, 32'(addr_err), 32'd0);
      @(posedge clk); #1;
    end else begin
      @(negedge clk);
      check({nm, " freeze_err"}, 32'(freeze), 32'd0);
      check({nm, " ready_err"}, 32'(ready), 32'd0);
      check({nm, " err_pre"}, 32'(addr_err), 32'd0);
      @(posedge clk); #1;
      MEM_R_EN = 1'b0;
      MEM_W_EN = 1'b0;
      @(negedge clk);
      check({nm, " addr_err"}, 32'(addr_err), 32'd1);
      check({nm, " no_ready"}, 32'(ready), 32'd0);
      check({nm, " rdata_err"}, mem_rdata, er);
      check({nm, " state_idle"}, 32'(dbg_state), 32'(MEM_IDLE));
      @(posedge clk); #1;
    end
  endtask

  // Reference model: applies the architectural rules to a word array.
  task automatic model_op(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d,
                          output logic e, output logic [31:0] er);
    int unsigned idx;
    idx = a >> 2;
    e = 1'b0;
    if (r && w) begin
      e = 1'b1;
    end else if (idx >= DEPTH) begin
      e = 1'b1;
      if (r) model_rdata = 32'h0;
    end else if (w) begin
      model_mem[idx] = d;
    end else begin
      model_rdata = model_mem[idx];
    end
    er = model_rdata;
  endtask

  initial begin
    logic        e;
    logic [31:0] er;
    logic [31:0] d;
    logic [31:0] a;
    logic        r;
    logic        w;
    int          kind;

    checks = 0;
    errors = 0;
    model_rdata = 32'h0;
    rst = 1'b1;
    MEM_R_EN = 1'b0;
    MEM_W_EN = 1'b0;
    ALU_result = 32'h0;
    ST_value = 32'h0;

    tbl[0]  = '{1'b0, 1'b1, 32'h010, 32'hDEADBEEF, 1'b0, 32'h00000000};
    tbl[1]  = '{1'b1, 1'b0, 32'h010, 32'h00000000, 1'b0, 32'hDEADBEEF};
    tbl[2]  = '{1'b0, 1'b1, 32'h020, 32'h00000011, 1'b0, 32'hDEADBEEF};
    tbl[3]  = '{1'b0, 1'b1, 32'h024, 32'h00000022, 1'b0, 32'hDEADBEEF};
    tbl[4]  = '{1'b1, 1'b0, 32'h020, 32'h00000000, 1'b0, 32'h00000011};
    tbl[5]  = '{1'b1, 1'b0, 32'h024, 32'h00000000, 1'b0, 32'h00000022};
    tbl[6]  = '{1'b1, 1'b0, 32'h100, 32'h00000000, 1'b1, 32'h00000000};
    tbl[7]  = '{1'b1, 1'b1, 32'h010, 32'h12345678, 1'b1, 32'h00000000};
    tbl[8]  = '{1'b1, 1'b0, 32'h010, 32'h00000000, 1'b0, 32'hDEADBEEF};
    tbl[9]  = '{1'b0, 1'b1, 32'h00B, 32'h000000A5, 1'b0, 32'hDEADBEEF};
    tbl[10] = '{1'b1, 1'b0, 32'h008, 32'h00000000, 1'b0, 32'h000000A5};
    tbl[11] = '{1'b0, 1'b1, 32'h008, 32'h00000077, 1'b0, 32'h000000A5};

    // Reset values.
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check("rst state", 32'(dbg_state), 32'(MEM_IDLE));
    check("rst freeze", 32'(freeze), 32'd0);
    check("rst ready", 32'(ready), 32'd0);
    check("rst addr_err", 32'(addr_err), 32'd0);
    check("rst rdata", mem_rdata, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Preload every word so later random reads have known data.
    for (int i = 0; i < DEPTH; i++) begin
      d = $urandom;
      run_op(1'b0, 1'b1, 32'(i * 4), d, 1'b0, model_rdata, "preload");
      model_mem[i] = d;
    end

    // Directed table, applied back-to-back.
    for (int i = 0; i < 12; i++) begin
      run_op(tbl[i].r, tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].e, tbl[i].er, $sformatf("tbl%0d", i));
      if (!tbl[i].e && tbl[i].w) model_mem[tbl[i].a >> 2] = tbl[i].d;
      model_rdata = tbl[i].er;
    end

    // Reset during a store still in BUSY: the store is dropped.
    MEM_R_EN = 1'b0;
    MEM_W_EN = 1'b1;
    ALU_result = 32'h08;
    ST_value = 32'h55;
    @(negedge clk);
    check("midrst freeze0", 32'(freeze), 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    check("midrst freeze1", 32'(freeze), 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    MEM_W_EN = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrst state", 32'(dbg_state), 32'(MEM_IDLE));
    check("midrst freeze", 32'(freeze), 32'd0);
    check("midrst ready", 32'(ready), 32'd0);
    check("midrst addr_err", 32'(addr_err), 32'd0);
    check("midrst rdata", mem_rdata, 32'h0);
    model_rdata = 32'h0;
    @(posedge clk); #1;
    run_op(1'b1, 1'b0, 32'h08, 32'h0, 1'b0, 32'h77, "midrst readback");
    model_rdata = 32'h77;

    // Random traffic against the reference model.
    for (int i = 0; i < 200; i++) begin
      kind = $urandom_range(0, 9);
      r = (kind <= 4);
      w = (kind == 0) || (kind >= 5);
      a = 32'($urandom_range(0, 32'h10F));
      d = $urandom;
      model_op(r, w, a, d, e, er);
      run_op(r, w, a, d, e, er, $sformatf("rand%0d", i));
    end

    MEM_R_EN = 1'b0;
    MEM_W_EN = 1'b0;
    @(negedge clk);
    check("final idle", 32'(dbg_state), 32'(MEM_IDLE));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
